// File: rtl/cordic_nco_feeder.sv
// rtl/cordic_nco_feeder.sv - burst NCO that folds, pre-scales and issues CORDIC rotation requests
module cordic_nco_feeder #(
   parameter int KINV  = 19898,
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [15:0]      cfg_freq,
   input  logic [15:0]      cfg_phase0,
   input  logic [14:0]      cfg_amp,
   input  logic [CNT_W-1:0] cfg_len,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [47:0]      request_put,
   output logic             EN_request_put,
   input  logic             RDY_request_put
);

   localparam logic [0:0]  S_IDLE = 1'b0;
   localparam logic [0:0]  S_RUN  = 1'b1;
   localparam logic [14:0] KINV_C = KINV[14:0];

   logic [0:0]       state;
   logic [15:0]      phase;
   logic [15:0]      freq;
   logic [14:0]      xs;
   logic [CNT_W-1:0] remaining;
   logic [31:0]      out_xz;
   logic [29:0]      prod;
   logic [14:0]      cfg_xs;

   assign prod   = {15'd0, cfg_amp} * {15'd0, KINV_C};
   assign cfg_xs = prod[29:15];

   // Quadrants 01/10 are rotated by pi and the sign moved onto x so |z| <= pi/2.
   function automatic logic [31:0] fold(input logic [15:0] p, input logic [14:0] a);
      logic [15:0] xv;
      xv = {1'b0, a};
      if (p[15] ^ p[14])
         return {-xv, p ^ 16'h8000};
      else
         return {xv, p};
   endfunction

   assign busy           = (state == S_RUN);
   assign EN_request_put = (state == S_RUN) && RDY_request_put;
   assign request_put    = {out_xz[31:16], 16'h0000, out_xz[15:0]};

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= S_IDLE;
         phase     <= '0;
         freq      <= '0;
         xs        <= '0;
         remaining <= '0;
         out_xz    <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               // A start coinciding with the done pulse belongs to the finished burst.
               if (start && !done) begin
                  if (cfg_len == '0) begin
                     done <= 1'b1;
                  end else begin
                     freq      <= cfg_freq;
                     xs        <= cfg_xs;
                     remaining <= cfg_len;
                     out_xz    <= fold(cfg_phase0, cfg_xs);
                     phase     <= cfg_phase0 + cfg_freq;
                     state     <= S_RUN;
                  end
               end
            end
            default: begin
               if (RDY_request_put) begin
                  if (remaining > CNT_W'(1)) begin
                     out_xz    <= fold(phase, xs);
                     phase     <= phase + freq;
                     remaining <= remaining - CNT_W'(1);
                  end else begin
                     done  <= 1'b1;
                     state <= S_IDLE;
                  end
               end
            end
         endcase
      end
   end

endmodule
